// File: rtl/skid_reg.sv
// Two-entry elastic register slice for a valid/ready pipeline link.
// Both the forward (nxt_*) and backward (prv_ready) paths leave this block straight from flops.
module skid_reg #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             prv_valid,
   output logic             prv_ready,
   input  logic [WIDTH-1:0] prv_data,
   output logic             nxt_valid,
   input  logic             nxt_ready,
   output logic [WIDTH-1:0] nxt_data,
   output logic [1:0]       occupancy
);

   // The encoding doubles as the occupancy count, so occupancy is a plain flop output.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] main_r;
   logic [WIDTH-1:0] skid_r;
   logic [WIDTH-1:0] main_nxt_s;
   logic [WIDTH-1:0] skid_nxt_s;
   logic             prv_ready_r;
   logic             in_fire_s;
   logic             out_fire_s;

   assign prv_ready  = prv_ready_r;
   assign nxt_valid  = (state_r != ST_EMPTY);
   assign nxt_data   = main_r;
   assign occupancy  = state_r;
   assign in_fire_s  = prv_valid && prv_ready_r;
   assign out_fire_s = nxt_valid && nxt_ready;

   // Next state and data selection for a normal (no reset, no flush) cycle.
   always_comb begin
      state_nxt_s = state_r;
      main_nxt_s  = main_r;
      skid_nxt_s  = skid_r;
      case (state_r)
         ST_EMPTY: begin
            if (in_fire_s) begin
               main_nxt_s  = prv_data;
               state_nxt_s = ST_BUSY;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_BUSY: begin
            if (in_fire_s && out_fire_s) begin
               main_nxt_s  = prv_data;
               state_nxt_s = ST_BUSY;
            end else if (in_fire_s) begin
               skid_nxt_s  = prv_data;
               state_nxt_s = ST_FULL;
            end else if (out_fire_s) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_BUSY;
            end
         end
         ST_FULL: begin
            // The skid entry is always the younger beat, so it moves forward on drain.
            if (out_fire_s) begin
               main_nxt_s  = skid_r;
               state_nxt_s = ST_BUSY;
            end else begin
               state_nxt_s = ST_FULL;
            end
         end
         default: begin
            state_nxt_s = ST_EMPTY;
         end
      endcase
   end

   // State, payload and registered ready flops; flush leaves the payload flops untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_EMPTY;
         prv_ready_r <= 1'b1;
         main_r      <= {WIDTH{1'b0}};
         skid_r      <= {WIDTH{1'b0}};
      end else if (flush) begin
         state_r     <= ST_EMPTY;
         prv_ready_r <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         prv_ready_r <= (state_nxt_s != ST_FULL);
         main_r      <= main_nxt_s;
         skid_r      <= skid_nxt_s;
      end
   end

   a_stall_stable: assert property (@(posedge clk) disable iff (rst)
      (nxt_valid && !nxt_ready && !flush) |=> (nxt_valid && $stable(nxt_data)));

   a_no_fire_full: assert property (@(posedge clk) disable iff (rst)
      !((state_r == ST_FULL) && in_fire_s));

   a_occ_legal: assert property (@(posedge clk) disable iff (rst)
      occupancy != 2'd3);

endmodule

// File: tb/tb_skid_reg.sv
// Directed and randomized checks of skid_reg (WIDTH=32) against hand-computed values and a queue model.
module tb_skid_reg;

   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic         flush;
   logic         prv_valid;
   logic         prv_ready;
   logic [W-1:0] prv_data;
   logic         nxt_valid;
   logic         nxt_ready;
   logic [W-1:0] nxt_data;
   logic [1:0]   occupancy;

   int compared   = 0;
   int mismatched = 0;

   skid_reg #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .prv_valid (prv_valid),
      .prv_ready (prv_ready),
      .prv_data  (prv_data),
      .nxt_valid (nxt_valid),
      .nxt_ready (nxt_ready),
      .nxt_data  (nxt_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic v, input logic [31:0] d,
                            input logic r, input logic [1:0] o);
      check({tag, ".nxt_valid"}, {31'd0, nxt_valid}, {31'd0, v});
      check({tag, ".nxt_data"},  nxt_data, d);
      check({tag, ".prv_ready"}, {31'd0, prv_ready}, {31'd0, r});
      check({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, o});
   endtask

   initial begin
      logic [W-1:0] q[$];
      logic         in_f;
      logic         out_f;

      rst = 1'b1; flush = 1'b0; prv_valid = 1'b0; prv_data = 32'h0; nxt_ready = 1'b0;
      tick();
      check_all("reset", 1'b0, 32'h0, 1'b1, 2'd0);
      rst = 1'b0;

      // Streaming at full throughput
      nxt_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         prv_valid = 1'b1; prv_data = 32'(i);
         tick();
         check_all("stream", 1'b1, 32'(i), 1'b1, 2'd1);
      end
      prv_valid = 1'b0;
      tick();
      check_all("stream_end", 1'b0, 32'h8, 1'b1, 2'd0);

      // Stall fill and drain
      nxt_ready = 1'b0; prv_valid = 1'b1; prv_data = 32'hA;
      tick();
      check_all("fill_a", 1'b1, 32'hA, 1'b1, 2'd1);
      prv_data = 32'hB;
      tick();
      check_all("fill_b", 1'b1, 32'hA, 1'b0, 2'd2);
      prv_data = 32'hDD;
      tick();
      check_all("full_hold", 1'b1, 32'hA, 1'b0, 2'd2);
      prv_valid = 1'b0; nxt_ready = 1'b1;
      tick();
      check_all("drain_a", 1'b1, 32'hB, 1'b1, 2'd1);
      tick();
      check_all("drain_b", 1'b0, 32'hB, 1'b1, 2'd0);

      // Flush while FULL with an offered beat
      nxt_ready = 1'b0; prv_valid = 1'b1; prv_data = 32'h11;
      tick();
      prv_data = 32'h22;
      tick();
      check_all("pre_flush", 1'b1, 32'h11, 1'b0, 2'd2);
      prv_data = 32'hC; flush = 1'b1;
      tick();
      check_all("flush_full", 1'b0, 32'h11, 1'b1, 2'd0);
      flush = 1'b0; prv_valid = 1'b0; nxt_ready = 1'b1;
      tick();
      check_all("after_flush", 1'b0, 32'h11, 1'b1, 2'd0);

      // Flush in BUSY with simultaneous in/out fire: both ignored
      prv_valid = 1'b1; prv_data = 32'h33;
      tick();
      check_all("busy_33", 1'b1, 32'h33, 1'b1, 2'd1);
      prv_data = 32'h44; flush = 1'b1;
      tick();
      check_all("flush_busy", 1'b0, 32'h33, 1'b1, 2'd0);
      flush = 1'b0; prv_valid = 1'b0;
      tick();
      check_all("after_flush2", 1'b0, 32'h33, 1'b1, 2'd0);

      // Reset mid-stream while BUSY
      nxt_ready = 1'b0; prv_valid = 1'b1; prv_data = 32'h66;
      tick();
      check_all("busy_66", 1'b1, 32'h66, 1'b1, 2'd1);
      prv_valid = 1'b0; rst = 1'b1;
      tick();
      check_all("mid_reset", 1'b0, 32'h0, 1'b1, 2'd0);
      rst = 1'b0; prv_valid = 1'b1; prv_data = 32'h55; nxt_ready = 1'b1;
      tick();
      check_all("post_reset", 1'b1, 32'h55, 1'b1, 2'd1);
      prv_valid = 1'b0;
      tick();
      check_all("post_reset_end", 1'b0, 32'h55, 1'b1, 2'd0);

      // Sustained simultaneous in/out fire: skid entry never used
      prv_valid = 1'b1; nxt_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         prv_data = 32'h100 + 32'(i);
         tick();
         check("sim.occupancy", {30'd0, occupancy}, 32'd1);
         check("sim.nxt_data", nxt_data, 32'h100 + 32'(i));
      end
      prv_valid = 1'b0;
      tick();
      check_all("sim_end", 1'b0, 32'h163, 1'b1, 2'd0);

      // Random traffic against a queue model
      for (int i = 0; i < 10000; i++) begin
         prv_valid = 1'($urandom_range(0, 1));
         nxt_ready = 1'($urandom_range(0, 1));
         prv_data  = $urandom;
         check("rnd.nxt_valid", {31'd0, nxt_valid}, {31'd0, (q.size() > 0)});
         check("rnd.prv_ready", {31'd0, prv_ready}, {31'd0, (q.size() < 2)});
         check("rnd.occupancy", {30'd0, occupancy}, 32'(q.size()));
         if (q.size() > 0) check("rnd.nxt_data", nxt_data, q[0]);
         out_f = (q.size() > 0) && nxt_ready;
         in_f  = prv_valid && (q.size() < 2);
         tick();
         if (out_f) void'(q.pop_front());
         if (in_f) q.push_back(prv_data);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
